// File: rtl/mvm3_pkg.sv
// Shared constants and state type for the 3x3 matrix-vector multiply controller.
package mvm3_pkg;

  localparam int N        = 3;
  localparam int ADDR_A_W = 4;
  localparam int ADDR_X_W = 2;
  localparam int IN_W     = 8;
  localparam int OUT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    OUTPUT
  } state_e;

endpackage

// File: rtl/mvm3_modn_cnt.sv
// Mod-N up counter with enable, synchronous clear and terminal-count flag.
module mvm3_modn_cnt #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == W'(N - 1));
  assign cnt_o = cnt_q;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mvm3_ctrl.sv
// Controller for a 3x3 matrix-vector multiply: loads A and x, then streams
// one row dot-product at a time to an external memory/MAC datapath.
module mvm3_ctrl #(
  parameter int N = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          wr_en_a,
  output logic [mvm3_pkg::ADDR_A_W-1:0] addr_a,
  output logic                          wr_en_x,
  output logic [mvm3_pkg::ADDR_X_W-1:0] addr_x,
  output logic                          clear_acc,
  output logic                          en_acc
);

  import mvm3_pkg::*;

  localparam logic [ADDR_A_W-1:0] NumA    = ADDR_A_W'(N * N);
  localparam logic [ADDR_A_W-1:0] LastIn  = ADDR_A_W'(N * N + N - 1);
  localparam logic [1:0]          LastRow = 2'(N - 1);

  state_e              state_q, state_d;
  logic [ADDR_A_W-1:0] k_q, k_d;
  logic [1:0]          r_q, r_d;
  logic                en_acc_q, clear_acc_q;
  logic [ADDR_X_W-1:0] col;
  logic                col_tc, col_en, col_clr;
  logic                accept;

  assign accept    = (state_q == LOAD) && s_valid;
  assign en_acc    = en_acc_q;
  assign clear_acc = clear_acc_q;

  mvm3_modn_cnt #(
    .N(N),
    .W(ADDR_X_W)
  ) u_col_cnt (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (col_en),
    .clr_i (col_clr),
    .cnt_o (col),
    .tc_o  (col_tc)
  );

  // Accumulator controls trail COMPUTE by one cycle to match memory read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      r_q         <= '0;
      en_acc_q    <= 1'b0;
      clear_acc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      r_q         <= r_d;
      en_acc_q    <= (state_q == COMPUTE);
      clear_acc_q <= (state_q == COMPUTE) && (col == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    col_en  = 1'b0;
    col_clr = 1'b0;
    s_ready = 1'b0;
    m_valid = 1'b0;
    wr_en_a = 1'b0;
    wr_en_x = 1'b0;
    addr_a  = '0;
    addr_x  = '0;
    unique case (state_q)
      IDLE: begin
        state_d = LOAD;
        k_d     = '0;
      end
      LOAD: begin
        s_ready = 1'b1;
        // The first N*N elements fill A, the remaining N fill x.
        if (k_q < NumA) begin
          addr_a = k_q;
        end else begin
          addr_x = ADDR_X_W'(k_q - NumA);
        end
        if (accept) begin
          wr_en_a = (k_q < NumA);
          wr_en_x = !(k_q < NumA);
          if (k_q == LastIn) begin
            state_d = COMPUTE;
            k_d     = '0;
            r_d     = '0;
            col_clr = 1'b1;
          end else begin
            k_d = k_q + ADDR_A_W'(1);
          end
        end
      end
      COMPUTE: begin
        addr_a = ADDR_A_W'(N) * ADDR_A_W'(r_q) + ADDR_A_W'(col);
        addr_x = col;
        col_en = 1'b1;
        if (col_tc) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = OUTPUT;
      end
      OUTPUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (r_q == LastRow) begin
            state_d = LOAD;
            r_d     = '0;
            k_d     = '0;
          end else begin
            state_d = COMPUTE;
            r_d     = r_q + 2'd1;
            col_clr = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mvm3_ctrl.sv
// Self-checking bench for mvm3_ctrl with a behavioural memory/MAC datapath.
module tb_mvm3_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, m_valid, wr_en_a, wr_en_x, clear_acc, en_acc;
  logic [3:0] addr_a;
  logic [1:0] addr_x;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_a [16];
  logic [7:0]  mem_x [4];
  logic [15:0] rd_a, rd_x, acc;
  logic [7:0]  frame [12];

  always #5 clk = ~clk;

  mvm3_ctrl #(.N(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .wr_en_a  (wr_en_a),
    .addr_a   (addr_a),
    .wr_en_x  (wr_en_x),
    .addr_x   (addr_x),
    .clear_acc(clear_acc),
    .en_acc   (en_acc)
  );

  // Datapath stand-in: synchronous-read memories feeding a multiply-accumulate.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_a <= '0;
      rd_x <= '0;
      acc  <= '0;
    end else begin
      if (wr_en_a) mem_a[addr_a] <= s_data;
      if (wr_en_x) mem_x[addr_x] <= s_data;
      rd_a <= {8'd0, mem_a[addr_a]};
      rd_x <= {8'd0, mem_x[addr_x]};
      if (en_acc) acc <= clear_acc ? 16'(rd_a * rd_x) : 16'(acc + rd_a * rd_x);
    end
  end

  function automatic logic [15:0] expected_row(input int r);
    int s = 0;
    for (int c = 0; c < 3; c++) s += int'(frame[3*r+c]) * int'(frame[9+c]);
    return 16'(s);
  endfunction

  function automatic logic [11:0] all_outputs();
    return {s_ready, m_valid, wr_en_a, wr_en_x, clear_acc, en_acc, addr_a, addr_x};
  endfunction

  task automatic randomize_frame();
    for (int n = 0; n < 12; n++) frame[n] = 8'($urandom_range(0, 255));
  endtask

  // Drives the current frame back-to-back; returns at the negedge of the first COMPUTE cycle.
  task automatic load_plain();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = frame[n];
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 'x;
  endtask

  task automatic finish_frame();
    for (int r = 0; r < 3; r++) begin
      int cnt = 0;
      while (!m_valid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      checks++;
      if (m_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL finish_timeout row=%0d: m_valid=%b, expected 1 within 20 cycles", r, m_valid);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (all_outputs() !== 12'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: outputs=%h, expected 000", all_outputs());
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || wr_en_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: s_ready=%b wr_en_a=%b, expected 0 0", s_ready, wr_en_a);
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: s_ready=%b m_valid=%b, expected 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_back_to_back();
    randomize_frame();
    for (int n = 0; n < 12; n++) begin
      logic expA, expX;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = frame[n];
      #1;
      expA = (n < 9);
      expX = (n >= 9);
      checks++;
      if (s_ready !== 1'b1 || wr_en_a !== expA || wr_en_x !== expX ||
          (expA && addr_a !== 4'(n)) || (expX && addr_x !== 2'(n - 9))) begin
        errors++;
        $display("[TB] FAIL b2b_write n=%0d: s_ready=%b wr_en_a=%b wr_en_x=%b addr_a=%0d addr_x=%0d, expected 1 %b %b addr %0d",
                 n, s_ready, wr_en_a, wr_en_x, addr_a, addr_x, expA, expX, expA ? n : n - 9);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 'x;
    #1;
    checks++;
    if (s_ready !== 1'b0 || wr_en_a !== 1'b0 || wr_en_x !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_ready_drop: s_ready=%b wr_en_a=%b wr_en_x=%b, expected 0 0 0", s_ready, wr_en_a, wr_en_x);
    end
    finish_frame();
  endtask

  task automatic test_gapped_load();
    int n = 0;
    int cyc = 0;
    randomize_frame();
    while (n < 12 && cyc < 200) begin
      logic v;
      @(negedge clk);
      v       = ($urandom_range(0, 2) != 0);
      s_valid = v;
      s_data  = v ? frame[n] : 'x;
      #1;
      checks++;
      if (v) begin
        if (s_ready !== 1'b1 || wr_en_a !== (n < 9) || wr_en_x !== (n >= 9) ||
            (n < 9 && addr_a !== 4'(n)) || (n >= 9 && addr_x !== 2'(n - 9))) begin
          errors++;
          $display("[TB] FAIL gapped_write n=%0d: wr_en_a=%b wr_en_x=%b addr_a=%0d addr_x=%0d, expected %b %b addr %0d",
                   n, wr_en_a, wr_en_x, addr_a, addr_x, n < 9, n >= 9, n < 9 ? n : n - 9);
        end
        n++;
      end else if (wr_en_a !== 1'b0 || wr_en_x !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gapped_idle n=%0d: wr_en_a=%b wr_en_x=%b, expected 0 0", n, wr_en_a, wr_en_x);
      end
      cyc++;
    end
    checks++;
    if (n != 12) begin
      errors++;
      $display("[TB] FAIL gapped_count: accepted=%0d, expected 12 within 200 cycles", n);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 'x;
    finish_frame();
  endtask

  // Walks all three rows cycle by cycle from the first COMPUTE cycle.
  task automatic test_compute(input bit useFixed);
    int fixedVals [12] = '{2, 2, 2, 3, 3, 3, 4, 4, 4, 2, 3, 4};
    if (useFixed) begin
      for (int n = 0; n < 12; n++) frame[n] = 8'(fixedVals[n]);
    end else begin
      randomize_frame();
    end
    load_plain();
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 5; j++) begin
        logic expEn, expClr, expMv;
        if (!(r == 0 && j == 0)) @(negedge clk);
        s_valid = 1'($urandom_range(0, 1));
        m_ready = (j == 4) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        expEn  = (j >= 1 && j <= 3);
        expClr = (j == 1);
        expMv  = (j == 4);
        checks++;
        if (en_acc !== expEn || clear_acc !== expClr || m_valid !== expMv ||
            s_ready !== 1'b0 || wr_en_a !== 1'b0 || wr_en_x !== 1'b0 ||
            (j < 3 && (addr_a !== 4'(3 * r + j) || addr_x !== 2'(j)))) begin
          errors++;
          $display("[TB] FAIL compute_cycle r=%0d j=%0d: addr_a=%0d addr_x=%0d en=%b clr=%b mv=%b sr=%b wa=%b wx=%b, expected addr_a=%0d addr_x=%0d en=%b clr=%b mv=%b",
                   r, j, addr_a, addr_x, en_acc, clear_acc, m_valid, s_ready, wr_en_a, wr_en_x,
                   3 * r + j, j, expEn, expClr, expMv);
        end
        if (j == 4) begin
          checks++;
          if (acc !== expected_row(r)) begin
            errors++;
            $display("[TB] FAIL compute_result r=%0d: y=%0d, expected %0d", r, acc, expected_row(r));
          end
        end
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL compute_reload: s_ready=%b m_valid=%b, expected 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_backpressure();
    randomize_frame();
    load_plain();
    for (int r = 0; r < 3; r++) begin
      int cnt = 0;
      logic [3:0] holdA;
      logic [1:0] holdX;
      while (!m_valid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      checks++;
      if (m_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_timeout row=%0d: m_valid=%b, expected 1 within 20 cycles", r, m_valid);
      end
      holdA = addr_a;
      holdX = addr_x;
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (m_valid !== 1'b1 || addr_a !== holdA || addr_x !== holdX || en_acc !== 1'b0 ||
            clear_acc !== 1'b0 || wr_en_a !== 1'b0 || wr_en_x !== 1'b0 || s_ready !== 1'b0 ||
            acc !== expected_row(r)) begin
          errors++;
          $display("[TB] FAIL bp_hold r=%0d i=%0d: mv=%b addr_a=%0d addr_x=%0d en=%b clr=%b y=%0d, expected mv=1 addr_a=%0d addr_x=%0d en=0 clr=0 y=%0d",
                   r, i, m_valid, addr_a, addr_x, en_acc, clear_acc, acc, holdA, holdX, expected_row(r));
        end
        @(negedge clk);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_reload: s_ready=%b, expected 1", s_ready);
    end
  endtask

  task automatic test_reset_mid_compute();
    randomize_frame();
    load_plain();
    repeat (4) @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (addr_a !== 4'd4 || addr_x !== 2'd1) begin
      errors++;
      $display("[TB] FAIL midreset_position: addr_a=%0d addr_x=%0d, expected 4 1", addr_a, addr_x);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== 12'd0) begin
      errors++;
      $display("[TB] FAIL midreset_async: outputs=%h, expected 000", all_outputs());
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (all_outputs() !== 12'd0) begin
        errors++;
        $display("[TB] FAIL midreset_hold: outputs=%h, expected 000", all_outputs());
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_restart: s_ready=%b, expected 1", s_ready);
    end
    test_compute(1'b0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped_load();
    test_compute(1'b1);
    test_compute(1'b0);
    test_backpressure();
    test_reset_mid_compute();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
